// File: rtl/mips_pkg.sv
// Shared widths, instruction tag encodings and memory-stage FSM encoding
// for the five-stage MIPS pipeline.
package mips_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_W  = 5;
   localparam int DEF_TAG_W  = 4;

   typedef enum logic [3:0] {
      INS_NOP    = 4'd0,
      INS_ALU    = 4'd1,
      INS_LOAD   = 4'd2,
      INS_STORE  = 4'd3,
      INS_BRANCH = 4'd4,
      INS_JUMP   = 4'd5
   } ins_type_e;

   typedef enum logic [1:0] {
      MS_IDLE  = 2'd0,
      MS_WAIT  = 2'd1,
      MS_ABORT = 2'd2
   } mem_state_e;

   // Word accesses only: both low address bits must be clear.
   function automatic logic word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/reg_exe_mem.sv
// EXE/MEM pipeline register: captures the EX bundle when enabled, holds otherwise.
// Async active-low clear turns the slot into a bubble.
module reg_exe_mem
   import mips_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_W  = DEF_REG_W,
   parameter int TAG_W  = DEF_TAG_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              wreg_d,
   input  logic              m2reg_d,
   input  logic              wmem_d,
   input  logic [DATA_W-1:0] aluR_d,
   input  logic [DATA_W-1:0] inB_d,
   input  logic [REG_W-1:0]  destR_d,
   input  logic [TAG_W-1:0]  ins_type_d,
   input  logic [TAG_W-1:0]  ins_number_d,
   output logic              wreg_q,
   output logic              m2reg_q,
   output logic              wmem_q,
   output logic [DATA_W-1:0] aluR_q,
   output logic [DATA_W-1:0] inB_q,
   output logic [REG_W-1:0]  destR_q,
   output logic [TAG_W-1:0]  ins_type_q,
   output logic [TAG_W-1:0]  ins_number_q
);

   // Slot register, frozen while the memory stage stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wreg_q       <= 1'b0;
         m2reg_q      <= 1'b0;
         wmem_q       <= 1'b0;
         aluR_q       <= {DATA_W{1'b0}};
         inB_q        <= {DATA_W{1'b0}};
         destR_q      <= {REG_W{1'b0}};
         ins_type_q   <= {TAG_W{1'b0}};
         ins_number_q <= {TAG_W{1'b0}};
      end else if (en) begin
         wreg_q       <= wreg_d;
         m2reg_q      <= m2reg_d;
         wmem_q       <= wmem_d;
         aluR_q       <= aluR_d;
         inB_q        <= inB_d;
         destR_q      <= destR_d;
         ins_type_q   <= ins_type_d;
         ins_number_q <= ins_number_d;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EXE/MEM slot, data-memory req/ack handshake with timeout,
// upstream stall generation and the registered MEM/WB boundary.
module mem_stage
   import mips_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int REG_W   = DEF_REG_W,
   parameter int TAG_W   = DEF_TAG_W,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_wreg,
   input  logic              ex_m2reg,
   input  logic              ex_wmem,
   input  logic [DATA_W-1:0] ex_aluR,
   input  logic [DATA_W-1:0] ex_inB,
   input  logic [REG_W-1:0]  ex_destR,
   input  logic [TAG_W-1:0]  EXE_ins_type,
   input  logic [TAG_W-1:0]  EXE_ins_number,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              mem_stall,
   output logic              mem_err,
   output logic              mem_wreg,
   output logic              mem_m2reg,
   output logic [DATA_W-1:0] mem_aluR,
   output logic [DATA_W-1:0] mem_rdata,
   output logic [REG_W-1:0]  mem_destR,
   output logic [TAG_W-1:0]  MEM_ins_type,
   output logic [TAG_W-1:0]  MEM_ins_number
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

   logic              m_wreg_q, m_m2reg_q, m_wmem_q;
   logic [DATA_W-1:0] m_aluR_q, m_inB_q;
   logic [REG_W-1:0]  m_destR_q;
   logic [TAG_W-1:0]  m_ins_type_q, m_ins_number_q;

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_op_s, misalign_s, abort_s, done_s;

   logic              mem_err_q, mem_err_d;
   logic              mem_wreg_q, mem_wreg_d, mem_m2reg_q, mem_m2reg_d;
   logic [DATA_W-1:0] mem_aluR_q, mem_aluR_d, mem_rdata_q, mem_rdata_d;
   logic [REG_W-1:0]  mem_destR_q, mem_destR_d;
   logic [TAG_W-1:0]  mem_type_q, mem_type_d, mem_num_q, mem_num_d;

   reg_exe_mem #(.DATA_W(DATA_W), .REG_W(REG_W), .TAG_W(TAG_W)) u_reg_exe_mem (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (~mem_stall),
      .wreg_d       (ex_wreg),
      .m2reg_d      (ex_m2reg),
      .wmem_d       (ex_wmem),
      .aluR_d       (ex_aluR),
      .inB_d        (ex_inB),
      .destR_d      (ex_destR),
      .ins_type_d   (EXE_ins_type),
      .ins_number_d (EXE_ins_number),
      .wreg_q       (m_wreg_q),
      .m2reg_q      (m_m2reg_q),
      .wmem_q       (m_wmem_q),
      .aluR_q       (m_aluR_q),
      .inB_q        (m_inB_q),
      .destR_q      (m_destR_q),
      .ins_type_q   (m_ins_type_q),
      .ins_number_q (m_ins_number_q)
   );

   assign dmem_addr  = m_aluR_q;
   assign dmem_wdata = m_inB_q;
   assign dmem_we    = m_wmem_q;

   // Handshake request, slot completion and upstream stall.
   always_comb begin
      mem_op_s   = m_m2reg_q | m_wmem_q;
      misalign_s = mem_op_s & ~word_aligned(m_aluR_q[1:0]);
      abort_s    = (state_q == MS_ABORT);
      dmem_req   = mem_op_s & ~misalign_s & ~abort_s;
      done_s     = ~mem_op_s | misalign_s | abort_s | (dmem_req & dmem_ack);
      mem_stall  = mem_op_s & ~done_s;
   end

   // Wait-state tracking; an ack on the limit cycle still completes normally.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         MS_IDLE: begin
            if (dmem_req && !dmem_ack) begin
               state_d = MS_WAIT;
               cnt_d   = CNT_W'(0);
            end else begin
               state_d = MS_IDLE;
            end
         end
         MS_WAIT: begin
            if (dmem_ack) begin
               state_d = MS_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_LIMIT) begin
                  state_d = MS_ABORT;
               end else begin
                  state_d = MS_WAIT;
               end
            end
         end
         MS_ABORT: begin
            state_d = MS_IDLE;
            cnt_d   = CNT_W'(0);
         end
         default: begin
            state_d = MS_IDLE;
            cnt_d   = CNT_W'(0);
         end
      endcase
   end

   // Next MEM/WB contents: the completed slot, or a bubble while stalled.
   always_comb begin
      mem_err_d = mem_err_q | misalign_s | abort_s;
      if (done_s) begin
         mem_wreg_d  = m_wreg_q & ~misalign_s & ~abort_s;
         mem_m2reg_d = m_m2reg_q;
         mem_aluR_d  = m_aluR_q;
         mem_rdata_d = (m_m2reg_q & dmem_req & dmem_ack) ? dmem_rdata : {DATA_W{1'b0}};
         mem_destR_d = m_destR_q;
         mem_type_d  = m_ins_type_q;
         mem_num_d   = m_ins_number_q;
      end else begin
         mem_wreg_d  = 1'b0;
         mem_m2reg_d = 1'b0;
         mem_aluR_d  = {DATA_W{1'b0}};
         mem_rdata_d = {DATA_W{1'b0}};
         mem_destR_d = {REG_W{1'b0}};
         mem_type_d  = {TAG_W{1'b0}};
         mem_num_d   = {TAG_W{1'b0}};
      end
   end

   // FSM, sticky error and MEM/WB registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= MS_IDLE;
         cnt_q       <= CNT_W'(0);
         mem_err_q   <= 1'b0;
         mem_wreg_q  <= 1'b0;
         mem_m2reg_q <= 1'b0;
         mem_aluR_q  <= {DATA_W{1'b0}};
         mem_rdata_q <= {DATA_W{1'b0}};
         mem_destR_q <= {REG_W{1'b0}};
         mem_type_q  <= {TAG_W{1'b0}};
         mem_num_q   <= {TAG_W{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_err_q   <= mem_err_d;
         mem_wreg_q  <= mem_wreg_d;
         mem_m2reg_q <= mem_m2reg_d;
         mem_aluR_q  <= mem_aluR_d;
         mem_rdata_q <= mem_rdata_d;
         mem_destR_q <= mem_destR_d;
         mem_type_q  <= mem_type_d;
         mem_num_q   <= mem_num_d;
      end
   end

   assign mem_err        = mem_err_q;
   assign mem_wreg       = mem_wreg_q;
   assign mem_m2reg      = mem_m2reg_q;
   assign mem_aluR       = mem_aluR_q;
   assign mem_rdata      = mem_rdata_q;
   assign mem_destR      = mem_destR_q;
   assign MEM_ins_type   = mem_type_q;
   assign MEM_ins_number = mem_num_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// stall/reset sequences and a randomized run against a behavioural model.
module tb_mem_stage;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_wreg, ex_m2reg, ex_wmem;
   logic [31:0] ex_aluR, ex_inB;
   logic [4:0]  ex_destR;
   logic [3:0]  EXE_ins_type, EXE_ins_number;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        mem_stall, mem_err, mem_wreg, mem_m2reg;
   logic [31:0] mem_aluR, mem_rdata;
   logic [4:0]  mem_destR;
   logic [3:0]  MEM_ins_type, MEM_ins_number;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   mem_stage #(.DATA_W(32), .REG_W(5), .TAG_W(4), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
      .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
      .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .mem_stall(mem_stall), .mem_err(mem_err),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_aluR(mem_aluR),
      .mem_rdata(mem_rdata), .mem_destR(mem_destR),
      .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number)
   );

   typedef struct {
      logic        wreg, m2reg, wmem;
      logic [31:0] aluR, inB;
      logic [4:0]  destR;
      logic [3:0]  typ, num;
   } ins_t;

   typedef struct {
      string       name;
      ins_t        ins;
      int          lat;        // cycles before ack; 99 = never
      logic [31:0] rdata;
      int          exp_stalls;
      logic        exp_req_seen, exp_wreg, exp_m2reg, exp_err;
      logic [31:0] exp_aluR, exp_rdata;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic ins_t mk(input logic w, input logic l, input logic s, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] d, input logic [3:0] n);
      ins_t i;
      i.wreg = w; i.m2reg = l; i.wmem = s; i.aluR = a; i.inB = b; i.destR = d;
      i.typ = l ? 4'd2 : (s ? 4'd3 : (w ? 4'd1 : 4'd0));
      i.num = n;
      return i;
   endfunction

   task automatic drive(input ins_t i);
      ex_wreg = i.wreg; ex_m2reg = i.m2reg; ex_wmem = i.wmem;
      ex_aluR = i.aluR; ex_inB = i.inB; ex_destR = i.destR;
      EXE_ins_type = i.typ; EXE_ins_number = i.num;
   endtask

   task automatic do_reset();
      drive(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'd0));
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      int   lat = v.lat;
      int   stalls = 0;
      logic req_seen = 1'b0;
      logic finished = 1'b0;
      do_reset();
      drive(v.ins);
      @(posedge clk); #1;
      drive(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'd0));
      for (int c = 0; c < 40 && !finished; c++) begin
         dmem_ack   = dmem_req && (lat == 0);
         dmem_rdata = v.rdata;
         #1;
         req_seen = req_seen | dmem_req;
         if (mem_stall) begin
            stalls++;
            if (lat > 0) lat--;
            @(posedge clk); #1;
         end else begin
            @(posedge clk); #1;
            finished = 1'b1;
         end
      end
      dmem_ack = 1'b0;
      check({v.name, " completes"}, 32'(finished), 32'd1);
      check({v.name, " stalls"}, 32'(stalls), 32'(v.exp_stalls));
      check({v.name, " req_seen"}, 32'(req_seen), 32'(v.exp_req_seen));
      check({v.name, " wreg"}, 32'(mem_wreg), 32'(v.exp_wreg));
      check({v.name, " m2reg"}, 32'(mem_m2reg), 32'(v.exp_m2reg));
      check({v.name, " aluR"}, mem_aluR, v.exp_aluR);
      check({v.name, " rdata"}, mem_rdata, v.exp_rdata);
      check({v.name, " destR"}, 32'(mem_destR), 32'(v.ins.destR));
      check({v.name, " tag"}, 32'(MEM_ins_number), 32'(v.ins.num));
      check({v.name, " err"}, 32'(mem_err), 32'(v.exp_err));
   endtask

   function automatic ins_t rand_ins(input int n);
      int          k = $urandom_range(0, 9);
      logic [31:0] a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 11) == 0) a = a | 32'($urandom_range(1, 3));
      return mk(k < 7, (k >= 4) && (k < 7), k >= 7, a, $urandom, 5'($urandom), 4'(n));
   endfunction

   vec_t vecs[7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"alu", mk(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 4'd1), 0, 32'h0,
                  0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0};
      vecs[1] = '{"load0", mk(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 4'd2), 0, 32'hDEADBEEF,
                  0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF};
      vecs[2] = '{"store3", mk(1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd0, 4'd3), 3, 32'h1111,
                  3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0};
      vecs[3] = '{"misload", mk(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd8, 4'd4), 0, 32'h2222,
                  0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h42, 32'h0};
      vecs[4] = '{"timeout", mk(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd9, 4'd5), 99, 32'h3333,
                  TIMEOUT, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0};
      vecs[5] = '{"acklast", mk(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd10, 4'd6), TIMEOUT - 1, 32'hCAFEF00D,
                  TIMEOUT - 1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'hCAFEF00D};
      vecs[6] = '{"misstore", mk(1'b0, 1'b0, 1'b1, 32'h81, 32'h5, 5'd0, 4'd7), 0, 32'h0,
                  0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h81, 32'h0};

      // Reset state
      do_reset();
      #1;
      check("reset req", 32'(dmem_req), 32'd0);
      check("reset stall", 32'(mem_stall), 32'd0);
      check("reset err", 32'(mem_err), 32'd0);
      check("reset wb", {mem_aluR[15:0], 11'(0), mem_wreg, MEM_ins_number}, 32'd0);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Delayed store: outputs stable, next instruction held, bubbles to WB
      begin
         int lat = 3;
         logic done = 1'b0;
         do_reset();
         drive(mk(1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd0, 4'd3));
         @(posedge clk); #1;
         drive(mk(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd9, 4'd9));
         for (int c = 0; c < 10 && !done; c++) begin
            dmem_ack = dmem_req && (lat == 0);
            #1;
            check("hold addr", dmem_addr, 32'h80);
            check("hold wdata", dmem_wdata, 32'hA5A5A5A5);
            check("hold we", 32'(dmem_we), 32'd1);
            if (mem_stall) begin
               lat--;
               @(posedge clk); #1;
               check("bubble tag", {27'(0), mem_wreg, MEM_ins_number}, 32'd0);
            end else begin
               done = 1'b1;
               @(posedge clk); #1;
            end
         end
         dmem_ack = 1'b0;
         check("store to wb", 32'(MEM_ins_number), 32'd3);
         drive(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'd0));
         @(posedge clk); #1;
         check("next to wb", 32'(MEM_ins_number), 32'd9);
         check("next aluR", mem_aluR, 32'h55);
      end

      // Reset asserted in the middle of a wait
      begin
         do_reset();
         drive(mk(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd3, 4'd4));
         @(posedge clk); #1;
         drive(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'd0));
         repeat (3) begin @(posedge clk); #1; end
         check("pre-reset stall", 32'(mem_stall), 32'd1);
         #1 rst_n = 1'b0;
         #1;
         check("async req drop", 32'(dmem_req), 32'd0);
         check("async stall drop", 32'(mem_stall), 32'd0);
         @(posedge clk); #1 rst_n = 1'b1;
         check("post-reset wb", {mem_aluR[23:0], 3'(0), mem_err, MEM_ins_number}, 32'd0);
         drive(mk(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd4, 4'd8));
         @(posedge clk); #1;
         dmem_ack = dmem_req; dmem_rdata = 32'h12345678;
         #1;
         check("post-reset idle", 32'(mem_stall), 32'd0);
         @(posedge clk); #1;
         dmem_ack = 1'b0;
         check("post-reset load", mem_rdata, 32'h12345678);
      end

      // Randomized run against a behavioural model
      begin
         ins_t        slot, cur;
         int          waited = 0;
         int          lat = 0;
         logic        m_err = 1'b0;
         logic        mem, mis, timed, req, done;
         logic        e_wreg, e_m2reg;
         logic [31:0] e_alu, e_rd;
         logic [4:0]  e_dst;
         logic [3:0]  e_typ, e_num;
         do_reset();
         slot = mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'd0);
         slot.typ = 4'd0;
         for (int n = 0; n < 400; n++) begin
            cur = rand_ins(n);
            drive(cur);
            mem   = slot.m2reg | slot.wmem;
            mis   = mem && (slot.aluR % 4 != 0);
            timed = mem && !mis && (waited == TIMEOUT);
            req   = mem && !mis && !timed;
            if (req && waited == 0) begin
               int r = $urandom_range(0, 19);
               lat = (r == 0) ? 99 : ((r < 8) ? 0 : $urandom_range(1, 4));
            end
            dmem_ack   = req ? (lat == 0) : ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
            #1;
            done = !mem || mis || timed || (req && dmem_ack);
            check("rnd req", 32'(dmem_req), 32'(req));
            check("rnd stall", 32'(mem_stall), 32'(mem && !done));
            if (req) check("rnd addr", dmem_addr, slot.aluR);
            if (req && slot.wmem) check("rnd wdata", dmem_wdata, slot.inB);
            if (done) begin
               e_wreg = slot.wreg && !mis && !timed; e_m2reg = slot.m2reg;
               e_alu = slot.aluR; e_dst = slot.destR; e_typ = slot.typ; e_num = slot.num;
               e_rd  = (slot.m2reg && req && dmem_ack) ? dmem_rdata : 32'h0;
            end else begin
               e_wreg = 1'b0; e_m2reg = 1'b0; e_alu = 32'h0; e_dst = 5'd0;
               e_typ = 4'd0; e_num = 4'd0; e_rd = 32'h0;
            end
            m_err = m_err | mis | timed;
            if (!done) begin
               waited++;
               if (lat > 0) lat--;
            end else begin
               waited = 0;
               slot = cur;
            end
            @(posedge clk); #1;
            check("rnd wreg", 32'(mem_wreg), 32'(e_wreg));
            check("rnd m2reg", 32'(mem_m2reg), 32'(e_m2reg));
            check("rnd aluR", mem_aluR, e_alu);
            check("rnd rdata", mem_rdata, e_rd);
            check("rnd destR", 32'(mem_destR), 32'(e_dst));
            check("rnd tags", {24'(0), MEM_ins_type, MEM_ins_number}, {24'(0), e_typ, e_num});
            check("rnd err", 32'(mem_err), 32'(m_err));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
